// File: rtl/simd_shift_seq_if.sv
// rtl/simd_shift_seq_if.sv - request/response bundle for simd_shift_seq
// Ports: request (in_valid/in_ready, mode and per-lane controls, shift_amt,
//        in_data), response (out_valid/out_ready, out_data), busy status.
//        master = issuer side, slave = shifter side.
interface simd_shift_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic        mode_unified;
  logic        uni_dir;
  logic        uni_arith;
  logic        hi_dir;
  logic        hi_arith;
  logic        lo_dir;
  logic        lo_arith;
  logic [11:0] shift_amt;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  modport master (
    output in_valid, mode_unified, uni_dir, uni_arith, hi_dir, hi_arith,
           lo_dir, lo_arith, shift_amt, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, mode_unified, uni_dir, uni_arith, hi_dir, hi_arith,
           lo_dir, lo_arith, shift_amt, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/simd_shift_seq.sv
// rtl/simd_shift_seq.sv - multi-cycle SIMD shifter, one 64-bit or two 32-bit lanes
// Ports: clk, rst_n (sync, active-low), bus (simd_shift_seq_if.slave).
//        STEP = max bits shifted per lane per cycle (power of 2, 1..32).
module simd_shift_seq #(
  parameter int STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  simd_shift_seq_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [5:0] STEP_AMT = 6'(STEP);
  localparam logic [5:0] LANE_MAX = 6'd32;

  logic [1:0]  state_q;
  logic [63:0] data_q;
  logic        unified_q;
  logic        dir_hi_q, ar_hi_q, dir_lo_q, ar_lo_q;
  logic [5:0]  rem_hi_q, rem_lo_q;
  logic        out_valid_q;

  // Unified mode reuses the hi lane slot for its single count and controls.
  logic [5:0] amt_hi_c, amt_lo_c;
  logic       dir_hi_c, ar_hi_c, dir_lo_c, ar_lo_c;

  always_comb begin
    amt_hi_c = '0;
    amt_lo_c = '0;
    dir_hi_c = 1'b0;
    ar_hi_c  = 1'b0;
    dir_lo_c = 1'b0;
    ar_lo_c  = 1'b0;
    if (bus.mode_unified) begin
      amt_hi_c = bus.shift_amt[5:0];
      dir_hi_c = bus.uni_dir;
      ar_hi_c  = bus.uni_arith & bus.uni_dir;
    end else begin
      // Any lane amount past 32 already shifts out every bit.
      amt_hi_c = (bus.shift_amt[11:6] > LANE_MAX) ? LANE_MAX : bus.shift_amt[11:6];
      amt_lo_c = (bus.shift_amt[5:0]  > LANE_MAX) ? LANE_MAX : bus.shift_amt[5:0];
      dir_hi_c = bus.hi_dir;
      ar_hi_c  = bus.hi_arith & bus.hi_dir;
      dir_lo_c = bus.lo_dir;
      ar_lo_c  = bus.lo_arith & bus.lo_dir;
    end
  end

  function automatic logic [63:0] shift64(input logic [63:0] d, input logic dir,
                                          input logic ar, input logic [5:0] s);
    if (!dir)     return d << s;
    else if (ar)  return 64'($signed(d) >>> s);
    else          return d >> s;
  endfunction

  function automatic logic [31:0] shift32(input logic [31:0] d, input logic dir,
                                          input logic ar, input logic [5:0] s);
    if (!dir)     return d << s;
    else if (ar)  return 32'($signed(d) >>> s);
    else          return d >> s;
  endfunction

  // A lane with rem = 0 gets s = 0 and therefore holds its value.
  logic [5:0]  s_hi, s_lo;
  logic [5:0]  rem_hi_nx, rem_lo_nx;
  logic [63:0] data_nx;

  always_comb begin
    s_hi      = (rem_hi_q > STEP_AMT) ? STEP_AMT : rem_hi_q;
    s_lo      = (rem_lo_q > STEP_AMT) ? STEP_AMT : rem_lo_q;
    rem_hi_nx = rem_hi_q - s_hi;
    rem_lo_nx = rem_lo_q - s_lo;
    if (unified_q)
      data_nx = shift64(data_q, dir_hi_q, ar_hi_q, s_hi);
    else
      data_nx = {shift32(data_q[63:32], dir_hi_q, ar_hi_q, s_hi),
                 shift32(data_q[31:0],  dir_lo_q, ar_lo_q, s_lo)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      unified_q   <= 1'b0;
      dir_hi_q    <= 1'b0;
      ar_hi_q     <= 1'b0;
      dir_lo_q    <= 1'b0;
      ar_lo_q     <= 1'b0;
      rem_hi_q    <= '0;
      rem_lo_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q    <= bus.in_data;
            unified_q <= bus.mode_unified;
            dir_hi_q  <= dir_hi_c;
            ar_hi_q   <= ar_hi_c;
            dir_lo_q  <= dir_lo_c;
            ar_lo_q   <= ar_lo_c;
            rem_hi_q  <= amt_hi_c;
            rem_lo_q  <= amt_lo_c;
            state_q   <= ((amt_hi_c | amt_lo_c) != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          data_q   <= data_nx;
          rem_hi_q <= rem_hi_nx;
          rem_lo_q <= rem_lo_nx;
          if (rem_hi_nx == '0 && rem_lo_nx == '0)
            state_q <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle only raises out_valid; the handshake follows.
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;

endmodule

// File: tb/tb_simd_shift_seq.sv
// tb/tb_simd_shift_seq.sv - scoreboard bench for simd_shift_seq (STEP = 8)
// Ports: none; drives simd_shift_seq_if as master, checks data and latency.
module tb_simd_shift_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simd_shift_seq_if bus();

  simd_shift_seq #(.STEP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: latency measured from accept edge to the first edge after which
  // out_valid is seen high; data compared at the handshake.
  logic prev_valid = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid && !prev_valid) begin
      rise_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at cycle %0d", cyc);
      end
    end
    if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("out_data", bus.out_data, e.data);
      chk("latency", 64'(rise_cyc - e.acc), 64'(e.lat));
    end
    prev_valid = bus.out_valid;
  end

  // ctl = {uni_dir, uni_arith, hi_dir, hi_arith, lo_dir, lo_arith};
  // fields of the inactive mode are replaced by noise.
  task automatic send(input logic uni, input logic [5:0] ctl, input logic [11:0] amt,
                      input logic [63:0] din, input logic [63:0] exp_d,
                      input int lat, input bit track);
    logic [5:0] c;
    logic [11:0] a;
    exp_t e;
    bit ok = 0;
    c = ctl;
    a = amt;
    if (uni) begin
      c[3:0]  = 4'($urandom);
      a[11:6] = 6'($urandom);
    end else begin
      c[5:4] = 2'($urandom);
    end
    @(negedge clk);
    bus.mode_unified = uni;
    {bus.uni_dir, bus.uni_arith, bus.hi_dir, bus.hi_arith, bus.lo_dir, bus.lo_arith} = c;
    bus.shift_amt = a;
    bus.in_data   = din;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    if (track) begin
      e.data = exp_d;
      e.lat  = lat;
      e.acc  = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 64'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.mode_unified = 1'b0;
    {bus.uni_dir, bus.uni_arith, bus.hi_dir, bus.hi_arith, bus.lo_dir, bus.lo_arith} = '0;
    bus.shift_amt = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    rst_n = 1'b1;

    send(0, 6'b00_11_00, {6'd2, 6'd3},  64'hFEDCBA9876543210, 64'hFFB72EA6B2A19080, 2, 1);
    send(1, 6'b00_0000,  12'd40,        64'hFEDCBA9876543210, 64'h5432100000000000, 6, 1);
    send(1, 6'b00_0000,  12'd0,         64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 1, 1);
    send(1, 6'b11_0000,  12'd63,        64'hF0000000A0000000, 64'hFFFFFFFFFFFFFFFF, 9, 1);
    send(1, 6'b11_0000,  12'd10,        64'hF0000000A0000000, 64'hFFFC000000280000, 3, 1);
    send(1, 6'b10_0000,  12'd35,        64'hFEDCBA9876543210, 64'h000000001FDB9753, 6, 1);
    send(0, 6'b00_00_10, {6'd1, 6'd40}, 64'hFEDCBA9876543210, 64'hFDB9753000000000, 5, 1);
    send(0, 6'b00_00_11, {6'd0, 6'd40}, 64'hFEDCBA9887654321, 64'hFEDCBA98FFFFFFFF, 5, 1);
    send(1, 6'b01_0000,  12'd4,         64'h8000000000000001, 64'h0000000000000010, 2, 1);
    send(0, 6'b00_11_00, {6'd40, 6'd0}, 64'h8000000000000000, 64'hFFFFFFFF00000000, 5, 1);
    drain();

    // Backpressure: result must hold and new requests must wait.
    bus.out_ready = 1'b0;
    send(1, 6'b00_0000, 12'd8, 64'h0000000000000001, 64'h0000000000000100, 2, 1);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.mode_unified = 1'b1;
      bus.shift_amt = 12'd1;
      bus.in_data = 64'h1234;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_out_data", bus.out_data, 64'h0000000000000100);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    send(1, 6'b10_0000, 12'd4, 64'h00000000000000F0, 64'h000000000000000F, 2, 1);
    drain();

    // Reset during SHIFT discards the op.
    send(1, 6'b00_0000, 12'd63, 64'h1, 64'h8000000000000000, 9, 0);
    repeat (3) @(negedge clk);
    chk("mid_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_busy", 64'(bus.busy), 64'd0);
    chk("mr_out_data", bus.out_data, 64'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    send(0, 6'b00_10_00, {6'd4, 6'd8}, 64'h12345678ABCDEF01, 64'h01234567CDEF0100, 2, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
